// File: rtl/traffic_phase_scheduler_if.sv
// Sensor/button inputs and phase outputs of the intersection sequencer.
// The master side drives sensors; the slave side is the scheduler.
interface traffic_phase_scheduler_if #(
    parameter int CW = 8
);
    logic          vs_nl;
    logic          vs_sl;
    logic          vs_el;
    logic          vs_wl;
    logic          psn;
    logic          pss;
    logic          pse;
    logic          psw;
    logic [4:0]    state1;
    logic [CW-1:0] phase_timer;
    logic [3:0]    ped_pending;
    logic [3:0]    left_pending;

    modport master (
        output vs_nl, vs_sl, vs_el, vs_wl,
        output psn, pss, pse, psw,
        input  state1, phase_timer,
        input  ped_pending, left_pending
    );

    modport slave (
        input  vs_nl, vs_sl, vs_el, vs_wl,
        input  psn, pss, pse, psw,
        output state1, phase_timer,
        output ped_pending, left_pending
    );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Intersection phase sequencer: through greens, yellows and on-demand
// left-turn phases, with latched left-lane and pedestrian requests.
module traffic_phase_scheduler #(
    parameter int GREEN_CYC  = 20,
    parameter int LEFT_CYC   = 10,
    parameter int YELLOW_CYC = 4,
    parameter int CW         = 8
) (
    input logic CLK,
    input logic rst,
    traffic_phase_scheduler_if.slave bus
);

    typedef enum logic [4:0] {
        N_S     = 5'b00000,
        E_W     = 5'b00001,
        N_S_Y   = 5'b00010,
        E_W_Y   = 5'b00011,
        N_NL    = 5'b00100,
        N_NL_Y  = 5'b00101,
        S_SL    = 5'b00110,
        S_SL_Y  = 5'b00111,
        W_WL    = 5'b01000,
        W_WL_Y  = 5'b01001,
        E_EL    = 5'b01010,
        E_EL_Y  = 5'b01011,
        SL_NL   = 5'b01100,
        SL_NL_Y = 5'b01101,
        EL_WL   = 5'b01110,
        EL_WL_Y = 5'b01111
    } phase_t;

    localparam logic [CW-1:0] G_LOAD = CW'(GREEN_CYC - 1);
    localparam logic [CW-1:0] L_LOAD = CW'(LEFT_CYC - 1);
    localparam logic [CW-1:0] Y_LOAD = CW'(YELLOW_CYC - 1);

    phase_t        state_q;
    phase_t        state_d;
    phase_t        nxt;
    logic [CW-1:0] timer_q;
    logic [CW-1:0] timer_d;
    logic [3:0]    left_q;
    logic [3:0]    left_d;
    logic [3:0]    left_clr;
    logic [3:0]    ped_q;
    logic [3:0]    ped_d;
    logic [3:0]    ped_clr;
    logic          illegal;
    logic          adv;

    function automatic logic [CW-1:0] load_of(input phase_t p);
        logic [CW-1:0] v;
        v = L_LOAD;
        case (p)
            N_S, E_W: v = G_LOAD;
            N_S_Y, E_W_Y, N_NL_Y, S_SL_Y,
            W_WL_Y, E_EL_Y, SL_NL_Y, EL_WL_Y: v = Y_LOAD;
            default: v = L_LOAD;
        endcase
        return v;
    endfunction

    // successor of each phase, decided on registered requests only
    always_comb begin
        nxt = N_S_Y;
        case (state_q)
            N_S:     nxt = N_S_Y;
            N_S_Y: begin
                if (left_q[3] && left_q[2])
                    nxt = SL_NL;
                else if (left_q[3])
                    nxt = N_NL;
                else if (left_q[2])
                    nxt = S_SL;
                else
                    nxt = E_W;
            end
            N_NL:    nxt = N_NL_Y;
            S_SL:    nxt = S_SL_Y;
            SL_NL:   nxt = SL_NL_Y;
            N_NL_Y,
            S_SL_Y,
            SL_NL_Y: nxt = E_W;
            E_W:     nxt = E_W_Y;
            E_W_Y: begin
                if (left_q[1] && left_q[0])
                    nxt = EL_WL;
                else if (left_q[1])
                    nxt = E_EL;
                else if (left_q[0])
                    nxt = W_WL;
                else
                    nxt = N_S;
            end
            E_EL:    nxt = E_EL_Y;
            W_WL:    nxt = W_WL_Y;
            EL_WL:   nxt = EL_WL_Y;
            E_EL_Y,
            W_WL_Y,
            EL_WL_Y: nxt = N_S;
            default: nxt = N_S_Y;
        endcase
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q - 1'b1;
        illegal = state_q[4];
        adv     = 1'b0;
        if (illegal) begin
            state_d = N_S_Y;
            timer_d = Y_LOAD;
            adv     = 1'b1;
        end else if (timer_q == '0) begin
            state_d = nxt;
            timer_d = load_of(nxt);
            adv     = 1'b1;
        end
    end

    // requests clear on the edge that enters their serving green
    always_comb begin
        left_clr = 4'b0000;
        ped_clr  = 4'b0000;
        if (adv) begin
            left_clr[3] = (state_d == N_NL) || (state_d == SL_NL);
            left_clr[2] = (state_d == S_SL) || (state_d == SL_NL);
            left_clr[1] = (state_d == E_EL) || (state_d == EL_WL);
            left_clr[0] = (state_d == W_WL) || (state_d == EL_WL);
            ped_clr[3]  = (state_d == E_W);
            ped_clr[2]  = (state_d == E_W);
            ped_clr[1]  = (state_d == N_S);
            ped_clr[0]  = (state_d == N_S);
        end
    end

    always_comb begin
        left_d = (left_q & ~left_clr)
               | {bus.vs_nl, bus.vs_sl, bus.vs_el, bus.vs_wl};
        ped_d  = (ped_q & ~ped_clr)
               | {bus.psn, bus.pss, bus.pse, bus.psw};
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= N_S;
            timer_q <= G_LOAD;
            left_q  <= 4'b0000;
            ped_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            left_q  <= left_d;
            ped_q   <= ped_d;
        end
    end

    assign bus.state1       = state_q;
    assign bus.phase_timer  = timer_q;
    assign bus.ped_pending  = ped_q;
    assign bus.left_pending = left_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed checks of phase sequencing, request latching and async reset
// for traffic_phase_scheduler at default timing parameters.
module tb_traffic_phase_scheduler;

    localparam int CW = 8;

    logic CLK;
    logic rst;
    int   total;
    int   bad;

    traffic_phase_scheduler_if #(.CW(CW)) intf ();

    traffic_phase_scheduler #(
        .GREEN_CYC (20),
        .LEFT_CYC  (10),
        .YELLOW_CYC(4),
        .CW        (CW)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(intf.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clear_inputs();
        intf.vs_nl = 1'b0;
        intf.vs_sl = 1'b0;
        intf.vs_el = 1'b0;
        intf.vs_wl = 1'b0;
        intf.psn   = 1'b0;
        intf.pss   = 1'b0;
        intf.pse   = 1'b0;
        intf.psw   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        step(3);
        total++;
        if (intf.state1 !== 5'b00000 || intf.phase_timer !== 8'd19) begin
            bad++;
            $display("FAIL reset_state: got %b/%0d want 00000/19",
                     intf.state1, intf.phase_timer);
        end
        total++;
        if (intf.ped_pending !== 4'b0000 || intf.left_pending !== 4'b0000) begin
            bad++;
            $display("FAIL reset_pending: got %b/%b want 0000/0000",
                     intf.ped_pending, intf.left_pending);
        end
        rst = 1'b1;
    endtask

    task automatic test_round();
        logic [4:0] ws;
        logic [7:0] wt;
        for (int i = 0; i <= 48; i++) begin
            if (i < 20) begin
                ws = 5'b00000; wt = 8'(19 - i);
            end else if (i < 24) begin
                ws = 5'b00010; wt = 8'(23 - i);
            end else if (i < 44) begin
                ws = 5'b00001; wt = 8'(43 - i);
            end else if (i < 48) begin
                ws = 5'b00011; wt = 8'(47 - i);
            end else begin
                ws = 5'b00000; wt = 8'd19;
            end
            total++;
            if (intf.state1 !== ws || intf.phase_timer !== wt) begin
                bad++;
                $display("FAIL round c%0d: got %b/%0d want %b/%0d",
                         i, intf.state1, intf.phase_timer, ws, wt);
            end
            if (i < 48) step(1);
        end
    endtask

    task automatic test_left_nl();
        step(5);
        intf.vs_nl = 1'b1;
        step(1);
        intf.vs_nl = 1'b0;
        total++;
        if (intf.left_pending !== 4'b1000) begin
            bad++;
            $display("FAIL nl_latch: got %b want 1000", intf.left_pending);
        end
        step(14);
        total++;
        if (intf.state1 !== 5'b00010 || intf.left_pending !== 4'b1000) begin
            bad++;
            $display("FAIL nl_hold: got %b/%b want 00010/1000",
                     intf.state1, intf.left_pending);
        end
        step(4);
        total++;
        if (intf.left_pending !== 4'b0000) begin
            bad++;
            $display("FAIL nl_clear: got %b want 0000", intf.left_pending);
        end
        for (int i = 0; i < 14; i++) begin
            total++;
            if (intf.state1 !== (i < 10 ? 5'b00100 : 5'b00101)) begin
                bad++;
                $display("FAIL nl_phase c%0d: got %b want %b", i,
                         intf.state1, (i < 10 ? 5'b00100 : 5'b00101));
            end
            step(1);
        end
        total++;
        if (intf.state1 !== 5'b00001 || intf.phase_timer !== 8'd19) begin
            bad++;
            $display("FAIL nl_exit: got %b/%0d want 00001/19",
                     intf.state1, intf.phase_timer);
        end
        step(24);
    endtask

    task automatic test_left_pairs();
        intf.vs_nl = 1'b1;
        intf.vs_sl = 1'b1;
        step(1);
        intf.vs_nl = 1'b0;
        intf.vs_sl = 1'b0;
        step(23);
        for (int i = 0; i < 14; i++) begin
            total++;
            if (intf.state1 !== (i < 10 ? 5'b01100 : 5'b01101)) begin
                bad++;
                $display("FAIL slnl_phase c%0d: got %b", i, intf.state1);
            end
            step(1);
        end
        total++;
        if (intf.state1 !== 5'b00001 || intf.left_pending !== 4'b0000) begin
            bad++;
            $display("FAIL slnl_exit: got %b/%b want 00001/0000",
                     intf.state1, intf.left_pending);
        end
        intf.vs_el = 1'b1;
        intf.vs_wl = 1'b1;
        step(1);
        intf.vs_el = 1'b0;
        intf.vs_wl = 1'b0;
        total++;
        if (intf.left_pending !== 4'b0011) begin
            bad++;
            $display("FAIL elwl_latch: got %b want 0011", intf.left_pending);
        end
        step(23);
        for (int i = 0; i < 14; i++) begin
            total++;
            if (intf.state1 !== (i < 10 ? 5'b01110 : 5'b01111)) begin
                bad++;
                $display("FAIL elwl_phase c%0d: got %b", i, intf.state1);
            end
            step(1);
        end
        total++;
        if (intf.state1 !== 5'b00000 || intf.phase_timer !== 8'd19) begin
            bad++;
            $display("FAIL elwl_exit: got %b/%0d want 00000/19",
                     intf.state1, intf.phase_timer);
        end
    endtask

    task automatic test_ped();
        intf.psn = 1'b1;
        step(1);
        intf.psn = 1'b0;
        total++;
        if (intf.ped_pending !== 4'b1000) begin
            bad++;
            $display("FAIL psn_latch: got %b want 1000", intf.ped_pending);
        end
        step(22);
        total++;
        if (intf.ped_pending !== 4'b1000 || intf.phase_timer !== 8'd0) begin
            bad++;
            $display("FAIL psn_hold: got %b/%0d want 1000/0",
                     intf.ped_pending, intf.phase_timer);
        end
        step(1);
        total++;
        if (intf.state1 !== 5'b00001 || intf.ped_pending !== 4'b0000) begin
            bad++;
            $display("FAIL psn_clear: got %b/%b want 00001/0000",
                     intf.state1, intf.ped_pending);
        end
        intf.psw = 1'b1;
        step(1);
        intf.psw = 1'b0;
        total++;
        if (intf.ped_pending !== 4'b0001) begin
            bad++;
            $display("FAIL psw_latch: got %b want 0001", intf.ped_pending);
        end
        step(22);
        total++;
        if (intf.ped_pending !== 4'b0001 || intf.state1 !== 5'b00011) begin
            bad++;
            $display("FAIL psw_hold: got %b/%b want 0001/00011",
                     intf.ped_pending, intf.state1);
        end
        step(1);
        total++;
        if (intf.state1 !== 5'b00000 || intf.ped_pending !== 4'b0000) begin
            bad++;
            $display("FAIL psw_clear: got %b/%b want 00000/0000",
                     intf.state1, intf.ped_pending);
        end
    endtask

    task automatic test_late_left();
        step(47);
        total++;
        if (intf.state1 !== 5'b00011 || intf.phase_timer !== 8'd0) begin
            bad++;
            $display("FAIL late_pos: got %b/%0d want 00011/0",
                     intf.state1, intf.phase_timer);
        end
        intf.vs_el = 1'b1;
        step(1);
        intf.vs_el = 1'b0;
        total++;
        if (intf.state1 !== 5'b00000 || intf.left_pending !== 4'b0010) begin
            bad++;
            $display("FAIL late_skip: got %b/%b want 00000/0010",
                     intf.state1, intf.left_pending);
        end
        step(48);
        total++;
        if (intf.state1 !== 5'b01010 || intf.left_pending !== 4'b0000) begin
            bad++;
            $display("FAIL late_serve: got %b/%b want 01010/0000",
                     intf.state1, intf.left_pending);
        end
        step(14);
        total++;
        if (intf.state1 !== 5'b00000 || intf.phase_timer !== 8'd19) begin
            bad++;
            $display("FAIL late_exit: got %b/%0d want 00000/19",
                     intf.state1, intf.phase_timer);
        end
    endtask

    task automatic test_async_reset();
        step(44);
        intf.vs_el = 1'b1;
        intf.psn   = 1'b1;
        step(1);
        intf.vs_el = 1'b0;
        intf.psn   = 1'b0;
        total++;
        if (intf.state1 !== 5'b00011 || intf.phase_timer !== 8'd2
            || intf.left_pending !== 4'b0010 || intf.ped_pending !== 4'b1000) begin
            bad++;
            $display("FAIL ar_pre: got %b/%0d/%b/%b want 00011/2/0010/1000",
                     intf.state1, intf.phase_timer,
                     intf.left_pending, intf.ped_pending);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (intf.state1 !== 5'b00000 || intf.phase_timer !== 8'd19
            || intf.left_pending !== 4'b0000 || intf.ped_pending !== 4'b0000) begin
            bad++;
            $display("FAIL ar_async: got %b/%0d/%b/%b want 00000/19/0000/0000",
                     intf.state1, intf.phase_timer,
                     intf.left_pending, intf.ped_pending);
        end
        step(1);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            total++;
            if (intf.state1 !== 5'b00000 || intf.phase_timer !== 8'(19 - i)) begin
                bad++;
                $display("FAIL ar_ns c%0d: got %b/%0d want 00000/%0d",
                         i, intf.state1, intf.phase_timer, 19 - i);
            end
            step(1);
        end
        total++;
        if (intf.state1 !== 5'b00010 || intf.phase_timer !== 8'd3) begin
            bad++;
            $display("FAIL ar_nsy: got %b/%0d want 00010/3",
                     intf.state1, intf.phase_timer);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_round();
        test_left_nl();
        test_left_pairs();
        test_ped();
        test_late_left();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Master intersection sequencer. Generates the 5-bit phase code `state1` consumed by pedestrian_crossing and the vehicle-light decoders.
- Cycles through the through-traffic phases and their yellows. Left-turn phases are inserted only when a left-lane vehicle request is pending.
- Latches pedestrian button presses until the serving green phase begins.

Parameters:
GREEN_CYC, 20, duration in cycles of N_S and E_W greens
LEFT_CYC, 10, duration in cycles of every left-turn green (N_NL, S_SL, W_WL, E_EL, SL_NL, EL_WL)
YELLOW_CYC, 4, duration in cycles of every yellow phase
CW, 8, phase-timer width; every duration must be ≤ 2^CW and ≥ 1

Ports:
CLK  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
vs_nl  input  1  north left-lane vehicle sensor
vs_sl  input  1  south left-lane vehicle sensor
vs_el  input  1  east left-lane vehicle sensor
vs_wl  input  1  west left-lane vehicle sensor
psn  input  1  north crosswalk pedestrian button
pss  input  1  south crosswalk pedestrian button
pse  input  1  east crosswalk pedestrian button
psw  input  1  west crosswalk pedestrian button
state1  output  5  current phase code
phase_timer  output  CW  cycles remaining in current phase minus 1
ped_pending  output  4  latched ped requests {n,s,e,w}
left_pending  output  4  latched left requests {nl,sl,el,wl}

Behaviour:
- Interface: one clock `CLK`. Reset `rst` is asynchronous and active-low.
- Phase codes (fixed):
  - N_S=00000, E_W=00001, N_S_Y=00010, E_W_Y=00011
  - N_NL=00100, N_NL_Y=00101, S_SL=00110, S_SL_Y=00111
  - W_WL=01000, W_WL_Y=01001, E_EL=01010, E_EL_Y=01011
  - SL_NL=01100, SL_NL_Y=01101, EL_WL=01110, EL_WL_Y=01111
  - Codes 1xxxx are never output.
- Reset (rst=0, asynchronous): state1=N_S, phase_timer=GREEN_CYC-1, ped_pending=0, left_pending=0.
  - Reset has priority in any state, mid-phase included.
  - After release, N_S lasts a full GREEN_CYC cycles.
- Timer:
  - On entry to a phase, phase_timer loads (duration-1); it decrements each cycle.
  - The state advances on the edge where phase_timer==0. Each phase is therefore exactly its duration in cycles. No idle cycle between phases.
- Transitions:
  - N_S→N_S_Y.
  - At N_S_Y expiry, branch on the registered left_pending nl/sl bits:
    - both set → SL_NL
    - nl only → N_NL
    - sl only → S_SL
    - neither → E_W
  - Each N/S left green → its own yellow → E_W.
  - E_W→E_W_Y.
  - At E_W_Y expiry, branch on el/wl:
    - both set → EL_WL
    - el only → E_EL
    - wl only → W_WL
    - neither → N_S
  - Each E/W left green → its own yellow → N_S.
- Request latches, per bit: next = (cur & ~clr) | sensor.
  - clr pulses on the cycle the serving green is entered:
    - nl: N_NL or SL_NL
    - sl: S_SL or SL_NL
    - el: E_EL or EL_WL
    - wl: W_WL or EL_WL
  - A sensor held high through entry re-latches the request; it is served again next round.
  - Branch decisions use the registered value only. A sensor first asserted in the expiry cycle of a yellow is not seen by that decision and is served the following round.
- Pedestrian latches use the same rule:
  - e,w cleared on entry to N_S.
  - n,s cleared on entry to E_W.
  - Presses do not alter timing.
- Illegal state register value (1xxxx): next state N_S_Y with timer YELLOW_CYC-1.
- Round period with no left requests: 2*(GREEN_CYC+YELLOW_CYC) = 48 cycles at defaults.

Test Plan:
1. Hold rst=0 for 3 cycles, then release with no inputs → state1=00000 immediately. Sequence N_S 20 cycles, N_S_Y 4, E_W 20, E_W_Y 4, back to N_S at cycle 48; phase_timer counts 19..0 in N_S.
2. 1-cycle vs_nl pulse at cycle 5 → left_pending=1000 until N_S_Y expiry. Then state1=00100 for 10 cycles with left_pending cleared, 00101 for 4 cycles, then 00001.
3. vs_nl and vs_sl pulsed together during N_S → 01100 for 10 cycles, then 01101 for 4 cycles, then 00001. Repeat with vs_el+vs_wl during E_W → 01110, then 01111, then 00000.
4. psw pulse during E_W → ped_pending=0001 held until the first cycle of N_S, then 0000. psn during N_S → ped_pending=1000, cleared on E_W entry.
5. vs_el first asserted in the last cycle of E_W_Y (phase_timer=0) → next state 00000, not 01010. Left_pending el stays set; the next E_W_Y expiry goes to 01010.
6. rst driven low mid E_W_Y (phase_timer=2) between clock edges → state1=00000 and all pending=0 without waiting for a clock edge. After release, full 20-cycle N_S.
